coin_collector: RTL and testbench
=================================

Name: coin_collector

Overview:
- Parametrised successor to the per-coin touch detectors: one block tracks N_COINS collectible tiles against Mario's bounding box.
- Keeps a per-coin collected flag and a saturating score.
- Issues one tile-clear request per collected coin over a valid/ready handshake, so the background owner can write SKY into that tile.
- Sits beside the Mario mover on the VGA clock domain.

Parameters:
- N_COINS, 2, number of coins tracked (1..64)
- ROW_W, 4, width of one tile row index
- COL_W, 5, width of one tile column index
- MARIO_WIDTH, 42, Mario box side in pixels
- BLOCK_WIDTH, 40, tile side in pixels
- SCORE_W, 8, score counter width
- COIN_VALUE, 1, points added per coin
- COMBO_WINDOW, 64, cycles for combo qualification (COIN_COMBO_EN only)
- COMBO_BONUS, 2, extra points per combo (COIN_COMBO_EN only)

Ports:
- vga_clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- mario_x  in  32 signed  Mario box left edge, pixels
- mario_y  in  32 signed  Mario box top edge, pixels
- coin_row  in  N_COINS*ROW_W  coin i row at bits [i*ROW_W +: ROW_W]; static
- coin_col  in  N_COINS*COL_W  coin i column, packed likewise; static
- rearm  in  1  restore all coins; score is kept
- clear_ready  in  1  background owner accepts the clear request
- clear_valid  out  1  tile-clear request
- clear_row  out  ROW_W  row of the tile to clear
- clear_col  out  COL_W  column of the tile to clear
- coin_event  out  1  one-cycle pulse per completed collection
- collected  out  N_COINS  per-coin collected flags
- score  out  SCORE_W  accumulated score
- all_collected  out  1  all flags set

Behaviour:
- Reset, evaluated every edge: state=SCAN, idx=0, collected=0, score=0, clear_valid=0, clear_row=0, clear_col=0, coin_event=0, all_collected=0, combo timer=0.
- Hit(i), combinational, signed compares:
  - tile box is tx=col*BLOCK_WIDTH, ty=row*BLOCK_WIDTH
  - Hit(i) = mario_x < tx+BLOCK_WIDTH && mario_x+MARIO_WIDTH > tx && mario_y < ty+BLOCK_WIDTH && mario_y+MARIO_WIDTH > ty
  - Edge-touching boxes do not hit.
- SCAN: examine coin idx each cycle.
  - If Hit(idx) and !collected[idx]: latch clear_row/clear_col, set clear_valid=1, go to CLEAR.
  - Otherwise idx advances, wrapping from N_COINS-1 to 0.
  - Worst-case detection latency N_COINS cycles; clear_valid rises the cycle after the hit scan.
- CLEAR: clear_valid, clear_row and clear_col stay stable until clear_valid&&clear_ready at an edge. On that edge:
  - clear_valid=0
  - collected[idx]=1
  - score += COIN_VALUE, saturating at 2^SCORE_W-1
  - coin_event=1 for exactly one cycle
  - idx advances with wrap
  - next state is DONE if all flags are now set, else SCAN
  - Mario leaving the tile during CLEAR does not cancel the request.
- DONE: all_collected=1; no requests; idle until rearm or reset.
- Simultaneous hits are serviced one per CLEAR in scan order starting at current idx; each is scored exactly once.
- An already-collected coin never triggers again until rearm.
- rearm, in SCAN or DONE: next edge sets collected=0, all_collected=0, idx=0, state=SCAN; score and combo timer are held. rearm is ignored during CLEAR; the handshake completes first.
- Reset mid-CLEAR: request abandoned, clear_valid=0 next edge, no score change.
- all_collected is registered from collected and asserts on the same edge as the last flag.

Optional Feature:
- Macro: COIN_COMBO_EN.
- Defined:
  - a timer loads COMBO_WINDOW on each collection and decrements to 0
  - a collection that completes while timer>0 adds COIN_VALUE+COMBO_BONUS, saturating
  - timer is cleared by reset, not by rearm
- Undefined: timer and bonus logic absent; every collection adds COIN_VALUE only.

Test Plan:
- Reset held 3 cycles, then released with no hit -> all outputs 0, clear_valid never asserts over 100 cycles.
- N_COINS=2; coin0=(6,6); Mario at (240,240), ready=1 -> clear_valid high 1 cycle with row=6,col=6; score=1; collected=01; coin_event single pulse.
- Same hit with clear_ready low 5 cycles -> clear_valid and row/col stable for 5 cycles; score changes only on the handshake edge.
- Both coins at the same tile, Mario overlapping, ready=1 -> two sequential requests, coin0 first; score=2; all_collected=1; no further requests while Mario stays.
- Mario at x=280 (right edge touching coin at col 6: 280 < 240+40 fails) -> no hit; at x=279 -> hit.
- Reset asserted while in CLEAR -> clear_valid=0 next cycle, score=0. Separately: rearm after all_collected -> collected=00 and score retained; with COIN_COMBO_EN, two collections 10 cycles apart -> score=1+3=4.

Source files
------------

// File: rtl/coin_collector.sv
// coin_collector: tracks N_COINS collectible tiles against Mario's bounding box
// on the VGA clock domain. It keeps a collected flag per coin and a saturating
// score. For each collected coin it sends one tile-clear request over a
// valid/ready handshake, so the background owner can paint that tile as sky.
// The optional combo bonus is compiled in when the macro COIN_COMBO_EN is
// defined. A collection that completes inside the combo window then earns
// COMBO_BONUS extra points.
module coin_collector #(
  parameter int N_COINS      = 2,
  parameter int ROW_W        = 4,
  parameter int COL_W        = 5,
  parameter int MARIO_WIDTH  = 42,
  parameter int BLOCK_WIDTH  = 40,
  parameter int SCORE_W      = 8,
  parameter int COIN_VALUE   = 1,
  parameter int COMBO_WINDOW = 64,
  parameter int COMBO_BONUS  = 2
) (
  input  logic                       vga_clock,
  input  logic                       reset,
  input  logic signed [31:0]         mario_x,
  input  logic signed [31:0]         mario_y,
  input  logic [N_COINS*ROW_W-1:0]   coin_row,
  input  logic [N_COINS*COL_W-1:0]   coin_col,
  input  logic                       rearm,
  input  logic                       clear_ready,
  output logic                       clear_valid,
  output logic [ROW_W-1:0]           clear_row,
  output logic [COL_W-1:0]           clear_col,
  output logic                       coin_event,
  output logic [N_COINS-1:0]         collected,
  output logic [SCORE_W-1:0]         score,
  output logic                       all_collected
);

  localparam int                     IDX_W     = (N_COINS > 1) ? $clog2(N_COINS) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(N_COINS - 1);
  localparam logic signed [31:0]     BLOCK_W_S = 32'(BLOCK_WIDTH);
  localparam logic signed [31:0]     MARIO_W_S = 32'(MARIO_WIDTH);
  localparam logic [SCORE_W:0]       SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};
  localparam logic [SCORE_W:0]       BASE_ADD  = (SCORE_W+1)'(COIN_VALUE);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     idx, idx_next, idx_wrap;
  logic                 clear_valid_next;
  logic [ROW_W-1:0]     clear_row_next;
  logic [COL_W-1:0]     clear_col_next;
  logic                 coin_event_next;
  logic [N_COINS-1:0]   collected_next;
  logic [SCORE_W-1:0]   score_next;
  logic                 all_collected_next;
  logic [SCORE_W:0]     add_amount;
  logic [SCORE_W:0]     score_sum;

  logic [ROW_W-1:0]     scan_row;
  logic [COL_W-1:0]     scan_col;
  logic signed [31:0]   tile_x, tile_y;
  logic                 hit;

`ifdef COIN_COMBO_EN
  localparam int                 TIMER_W    = $clog2(COMBO_WINDOW + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(COMBO_WINDOW);
  localparam logic [SCORE_W:0]   COMBO_ADD  = BASE_ADD + (SCORE_W+1)'(COMBO_BONUS);

  logic [TIMER_W-1:0]   combo_timer, combo_timer_next;
`else
  logic                 unused_combo_cfg;
  assign unused_combo_cfg = ^{32'(COMBO_WINDOW), 32'(COMBO_BONUS)};
`endif

  // Overlap test between Mario's box and the tile of the coin under scan; touching edges do not count
  always_comb begin
    scan_row = coin_row[idx*ROW_W +: ROW_W];
    scan_col = coin_col[idx*COL_W +: COL_W];
    tile_x   = $signed({{(32-COL_W){1'b0}}, scan_col}) * BLOCK_W_S;
    tile_y   = $signed({{(32-ROW_W){1'b0}}, scan_row}) * BLOCK_W_S;
    hit      = (mario_x < tile_x + BLOCK_W_S) && (mario_x + MARIO_W_S > tile_x) &&
               (mario_y < tile_y + BLOCK_W_S) && (mario_y + MARIO_W_S > tile_y);
  end

  // Next-state and next-output logic for the scan / clear / done sequence
  always_comb begin
    state_next         = state;
    idx_next           = idx;
    clear_valid_next   = clear_valid;
    clear_row_next     = clear_row;
    clear_col_next     = clear_col;
    coin_event_next    = 1'b0;
    collected_next     = collected;
    score_next         = score;
    all_collected_next = all_collected;
    idx_wrap           = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    add_amount         = BASE_ADD;
`ifdef COIN_COMBO_EN
    combo_timer_next   = (combo_timer != '0) ? combo_timer - 1'b1 : '0;
    if (combo_timer != '0) begin
      add_amount = COMBO_ADD;
    end
`endif
    score_sum          = {1'b0, score} + add_amount;

    case (state)
      SCAN: begin
        if (rearm) begin
          collected_next     = '0;
          all_collected_next = 1'b0;
          idx_next           = '0;
        end else if (hit && !collected[idx]) begin
          clear_row_next   = scan_row;
          clear_col_next   = scan_col;
          clear_valid_next = 1'b1;
          state_next       = CLEAR;
        end else begin
          idx_next = idx_wrap;
        end
      end
      CLEAR: begin
        if (clear_ready) begin
          clear_valid_next    = 1'b0;
          collected_next[idx] = 1'b1;
          score_next          = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
          coin_event_next     = 1'b1;
          idx_next            = idx_wrap;
`ifdef COIN_COMBO_EN
          combo_timer_next    = TIMER_LOAD;
`endif
          if (&collected_next) begin
            all_collected_next = 1'b1;
            state_next         = DONE;
          end else begin
            state_next = SCAN;
          end
        end
      end
      DONE: begin
        if (rearm) begin
          collected_next     = '0;
          all_collected_next = 1'b0;
          idx_next           = '0;
          state_next         = SCAN;
        end
      end
      default: begin
        state_next = SCAN;
      end
    endcase
  end

  // State register
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state <= SCAN;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: scan index, request, flags, score and combo timer
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      idx           <= '0;
      clear_valid   <= 1'b0;
      clear_row     <= '0;
      clear_col     <= '0;
      coin_event    <= 1'b0;
      collected     <= '0;
      score         <= '0;
      all_collected <= 1'b0;
`ifdef COIN_COMBO_EN
      combo_timer   <= '0;
`endif
    end else begin
      idx           <= idx_next;
      clear_valid   <= clear_valid_next;
      clear_row     <= clear_row_next;
      clear_col     <= clear_col_next;
      coin_event    <= coin_event_next;
      collected     <= collected_next;
      score         <= score_next;
      all_collected <= all_collected_next;
`ifdef COIN_COMBO_EN
      combo_timer   <= combo_timer_next;
`endif
    end
  end

endmodule

// File: tb/tb_coin_collector.sv
// tb_coin_collector: directed testbench for coin_collector with two coins.
// The expected score sums depend on whether COIN_COMBO_EN is defined.
module tb_coin_collector;

  localparam int N_COINS = 2;
  localparam int ROW_W   = 4;
  localparam int COL_W   = 5;
  localparam int SCORE_W = 8;

`ifdef COIN_COMBO_EN
  localparam int EXP_TWO   = 4;
  localparam int EXP_REARM = 10;
`else
  localparam int EXP_TWO   = 2;
  localparam int EXP_REARM = 4;
`endif

  logic                      vga_clock = 1'b0;
  logic                      reset;
  logic signed [31:0]        mario_x, mario_y;
  logic [N_COINS*ROW_W-1:0]  coin_row;
  logic [N_COINS*COL_W-1:0]  coin_col;
  logic                      rearm;
  logic                      clear_ready;
  logic                      clear_valid;
  logic [ROW_W-1:0]          clear_row;
  logic [COL_W-1:0]          clear_col;
  logic                      coin_event;
  logic [N_COINS-1:0]        collected;
  logic [SCORE_W-1:0]        score;
  logic                      all_collected;

  int compared   = 0;
  int mismatched = 0;

  // 10 ns VGA clock
  always #5 vga_clock = ~vga_clock;

  coin_collector #(
    .N_COINS(N_COINS), .ROW_W(ROW_W), .COL_W(COL_W), .MARIO_WIDTH(42),
    .BLOCK_WIDTH(40), .SCORE_W(SCORE_W), .COIN_VALUE(1),
    .COMBO_WINDOW(64), .COMBO_BONUS(2)
  ) dut (
    .vga_clock(vga_clock), .reset(reset), .mario_x(mario_x), .mario_y(mario_y),
    .coin_row(coin_row), .coin_col(coin_col), .rearm(rearm), .clear_ready(clear_ready),
    .clear_valid(clear_valid), .clear_row(clear_row), .clear_col(clear_col),
    .coin_event(coin_event), .collected(collected), .score(score),
    .all_collected(all_collected)
  );

  task automatic tick();
    @(posedge vga_clock);
    #1;
  endtask

  task automatic park_mario();
    mario_x = -500;
    mario_y = -500;
  endtask

  task automatic do_reset();
    park_mario();
    rearm = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int vcount;
    coin_row    = {4'd2, 4'd6};
    coin_col    = {5'd10, 5'd6};
    clear_ready = 1'b1;
    do_reset();
    compared++;
    if (clear_valid !== 1'b0 || clear_row !== 4'd0 || clear_col !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_request: valid=%b row=%0d col=%0d expected 0/0/0", clear_valid, clear_row, clear_col);
    end
    compared++;
    if (score !== 8'd0 || collected !== 2'b00 || all_collected !== 1'b0 || coin_event !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: score=%0d collected=%b all=%b event=%b expected all 0", score, collected, all_collected, coin_event);
    end
    vcount = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (clear_valid !== 1'b0) vcount++;
    end
    compared++;
    if (vcount != 0) begin
      mismatched++;
      $display("[TB] FAIL idle_no_request: valid cycles=%0d expected 0", vcount);
    end
  endtask

  task automatic test_single_hit();
    int vcount;
    do_reset();
    clear_ready = 1'b1;
    mario_x = 240;
    mario_y = 240;
    tick();
    compared++;
    if (clear_valid !== 1'b1 || clear_row !== 4'd6 || clear_col !== 5'd6) begin
      mismatched++;
      $display("[TB] FAIL single_request: valid=%b row=%0d col=%0d expected 1/6/6", clear_valid, clear_row, clear_col);
    end
    tick();
    compared++;
    if (clear_valid !== 1'b0 || coin_event !== 1'b1 || score !== 8'd1 || collected !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL single_handshake: valid=%b event=%b score=%0d collected=%b expected 0/1/1/01", clear_valid, coin_event, score, collected);
    end
    tick();
    compared++;
    if (coin_event !== 1'b0 || all_collected !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_pulse: event=%b all=%b expected 0/0", coin_event, all_collected);
    end
    vcount = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (clear_valid !== 1'b0) vcount++;
    end
    compared++;
    if (vcount != 0 || score !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL single_no_retrigger: valid cycles=%0d score=%0d expected 0/1", vcount, score);
    end
  endtask

  task automatic test_backpressure();
    int unstable;
    do_reset();
    clear_ready = 1'b0;
    mario_x = 240;
    mario_y = 240;
    tick();
    compared++;
    if (clear_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL stall_request: valid=%b expected 1", clear_valid);
    end
    unstable = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) park_mario();
      tick();
      if (clear_valid !== 1'b1 || clear_row !== 4'd6 || clear_col !== 5'd6 ||
          score !== 8'd0 || coin_event !== 1'b0) unstable++;
    end
    compared++;
    if (unstable != 0) begin
      mismatched++;
      $display("[TB] FAIL stall_stable: unstable cycles=%0d expected 0", unstable);
    end
    clear_ready = 1'b1;
    tick();
    compared++;
    if (clear_valid !== 1'b0 || score !== 8'd1 || coin_event !== 1'b1 || collected !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL stall_handshake: valid=%b score=%0d event=%b collected=%b expected 0/1/1/01", clear_valid, score, coin_event, collected);
    end
    tick();
    compared++;
    if (clear_valid !== 1'b0 || coin_event !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stall_after: valid=%b event=%b expected 0/0", clear_valid, coin_event);
    end
  endtask

  task automatic test_reset_mid_clear();
    int vcount;
    do_reset();
    clear_ready = 1'b0;
    mario_x = 240;
    mario_y = 240;
    tick();
    compared++;
    if (clear_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midclear_request: valid=%b expected 1", clear_valid);
    end
    reset = 1'b1;
    tick();
    compared++;
    if (clear_valid !== 1'b0 || score !== 8'd0 || collected !== 2'b00 || coin_event !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midclear_reset: valid=%b score=%0d collected=%b event=%b expected 0/0/00/0", clear_valid, score, collected, coin_event);
    end
    park_mario();
    reset = 1'b0;
    clear_ready = 1'b1;
    vcount = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (clear_valid !== 1'b0) vcount++;
    end
    compared++;
    if (vcount != 0 || score !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL midclear_abandoned: valid cycles=%0d score=%0d expected 0/0", vcount, score);
    end
  endtask

  task automatic test_edge_touch();
    int vcount;
    int seen;
    do_reset();
    clear_ready = 1'b1;
    mario_x = 280; mario_y = 240;
    vcount = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (clear_valid !== 1'b0) vcount++; end
    mario_x = 240; mario_y = 198;
    for (int c = 0; c < 10; c++) begin tick(); if (clear_valid !== 1'b0) vcount++; end
    mario_x = 198; mario_y = 240;
    for (int c = 0; c < 10; c++) begin tick(); if (clear_valid !== 1'b0) vcount++; end
    compared++;
    if (vcount != 0 || collected !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL edge_touch_nohit: valid cycles=%0d collected=%b expected 0/00", vcount, collected);
    end
    mario_x = 279; mario_y = 240;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (clear_valid === 1'b1 && clear_row === 4'd6 && clear_col === 5'd6) seen++;
    end
    compared++;
    if (seen != 1 || collected !== 2'b01 || score !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL edge_overlap_hit: requests=%0d collected=%b score=%0d expected 1/01/1", seen, collected, score);
    end
  endtask

  task automatic test_back_to_back();
    int vcount;
    int ev;
    logic [1:0] first_coll;
    coin_row = {4'd6, 4'd6};
    coin_col = {5'd6, 5'd6};
    do_reset();
    clear_ready = 1'b1;
    mario_x = 240;
    mario_y = 240;
    vcount = 0;
    ev = 0;
    first_coll = 2'bxx;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (clear_valid === 1'b1) vcount++;
      if (coin_event === 1'b1) begin
        ev++;
        if (ev == 1) first_coll = collected;
      end
    end
    compared++;
    if (vcount != 2 || ev != 2 || first_coll !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL b2b_sequence: requests=%0d events=%0d first=%b expected 2/2/01", vcount, ev, first_coll);
    end
    compared++;
    if (collected !== 2'b11 || all_collected !== 1'b1 || score !== 8'(EXP_TWO)) begin
      mismatched++;
      $display("[TB] FAIL b2b_final: collected=%b all=%b score=%0d expected 11/1/%0d", collected, all_collected, score, EXP_TWO);
    end
    vcount = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (clear_valid !== 1'b0 || all_collected !== 1'b1) vcount++;
    end
    compared++;
    if (vcount != 0) begin
      mismatched++;
      $display("[TB] FAIL b2b_done_idle: bad cycles=%0d expected 0", vcount);
    end
  endtask

  task automatic test_rearm();
    int ev;
    park_mario();
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    compared++;
    if (collected !== 2'b00 || all_collected !== 1'b0 || score !== 8'(EXP_TWO)) begin
      mismatched++;
      $display("[TB] FAIL rearm_restore: collected=%b all=%b score=%0d expected 00/0/%0d", collected, all_collected, score, EXP_TWO);
    end
    mario_x = 240;
    mario_y = 240;
    ev = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (coin_event === 1'b1) ev++;
    end
    compared++;
    if (ev != 2 || collected !== 2'b11 || all_collected !== 1'b1 || score !== 8'(EXP_REARM)) begin
      mismatched++;
      $display("[TB] FAIL rearm_recollect: events=%0d collected=%b all=%b score=%0d expected 2/11/1/%0d", ev, collected, all_collected, score, EXP_REARM);
    end
  endtask

  task automatic test_score_sequence();
    int got;
    coin_row = {4'd2, 4'd6};
    coin_col = {5'd10, 5'd6};
    do_reset();
    clear_ready = 1'b1;
    mario_x = 240;
    mario_y = 240;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      tick();
      if (coin_event === 1'b1) got = 1;
    end
    compared++;
    if (got != 1 || score !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL seq_first: event seen=%0d score=%0d expected 1/1", got, score);
    end
    repeat (5) tick();
    mario_x = 400;
    mario_y = 80;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      tick();
      if (coin_event === 1'b1) got = 1;
    end
    compared++;
    if (got != 1 || score !== 8'(EXP_TWO) || collected !== 2'b11 || all_collected !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL seq_second: event seen=%0d score=%0d collected=%b all=%b expected 1/%0d/11/1", got, score, collected, all_collected, EXP_TWO);
    end
  endtask

  // Runaway guard
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    reset       = 1'b1;
    rearm       = 1'b0;
    clear_ready = 1'b0;
    mario_x     = -500;
    mario_y     = -500;
    coin_row    = '0;
    coin_col    = '0;
    test_reset();
    test_single_hit();
    test_backpressure();
    test_reset_mid_clear();
    test_edge_touch();
    test_back_to_back();
    test_rearm();
    test_score_sequence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
